// File: rtl/sc_mon_pkg.sv
// Shared constants and helpers for the sc counter monitor blocks.
package sc_mon_pkg;

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX  = 3'd7;
  localparam logic [3:0]       DROP_MAX = 4'd15;

  typedef enum logic [1:0] {
    EV_NONE = 2'b00,
    EV_CLR  = 2'b01,
    EV_SAT  = 2'b10,
    EV_ILL  = 2'b11
  } ev_code_e;

  // A step is legal if the counter holds, increments without wrapping,
  // or lands on zero right after a sampled clear request.
  function automatic logic step_legal(input logic [CNT_W-1:0] prev,
                                      input logic [CNT_W-1:0] cur,
                                      input logic             clr_q);
    return (cur == prev)
        || ((prev != CNT_MAX) && (cur == prev + CNT_W'(1)))
        || (clr_q && (cur == '0));
  endfunction

endpackage

// File: rtl/sc_ev_fifo.sv
// Generic synchronous FIFO; head is presented combinationally and forced to 0 when empty.
module sc_ev_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/sc_event_logger.sv
// Watches the sc counter output, classifies clear/saturation/illegal steps,
// timestamps them and queues them for a valid/ready consumer.
module sc_event_logger
  import sc_mon_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TS_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt,
  input  logic             ctr_rst,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [1:0]       ev_code,
  output logic [TS_W-1:0]  ev_ts,
  output logic             ovf,
  output logic [3:0]       drop_cnt,
  output logic             err
);

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [CNT_W-1:0] prev_cnt_q;
  logic             ctr_rst_q;
  logic             armed_q;
  logic             ovf_q, ovf_d;
  logic [3:0]       drop_cnt_q, drop_cnt_d;
  logic             err_q, err_d;

  ev_code_e         ev_code_d;
  logic             ill;
  logic             ev_push;
  logic             pop_req;
  logic             drop;
  logic             fifo_full, fifo_empty;
  logic [TS_W+1:0]  fifo_dout;

  always_comb begin
    ev_code_d = EV_NONE;
    ill       = 1'b0;
    if (armed_q) begin
      ill = !step_legal(prev_cnt_q, cnt, ctr_rst_q);
      if (ctr_rst && !ctr_rst_q)
        ev_code_d = EV_CLR;
      else if (ill)
        ev_code_d = EV_ILL;
      else if ((prev_cnt_q == CNT_MAX - CNT_W'(1)) && (cnt == CNT_MAX))
        ev_code_d = EV_SAT;
    end
  end

  assign ev_push = (ev_code_d != EV_NONE);
  assign pop_req = ev_valid && ev_ready;
  // Full implies non-empty, so a pending pop always frees a slot.
  assign drop    = ev_push && fifo_full && !pop_req;

  always_comb begin
    ts_d       = ts_q + TS_W'(1);
    err_d      = ill;
    ovf_d      = ovf_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != DROP_MAX)) drop_cnt_d = drop_cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q       <= '0;
      prev_cnt_q <= '0;
      ctr_rst_q  <= 1'b0;
      armed_q    <= 1'b0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      prev_cnt_q <= cnt;
      ctr_rst_q  <= ctr_rst;
      armed_q    <= 1'b1;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
      err_q      <= err_d;
    end
  end

  sc_ev_fifo #(
    .WIDTH (TS_W + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ev_push),
    .din   ({ev_code_d, ts_q}),
    .pop   (ev_ready),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ev_valid = !fifo_empty;
  assign ev_code  = fifo_dout[TS_W+1:TS_W];
  assign ev_ts    = fifo_dout[TS_W-1:0];
  assign ovf      = ovf_q;
  assign drop_cnt = drop_cnt_q;
  assign err      = err_q;

endmodule
